// File: rtl/vip_sobel_edge_detector_8bit.sv
// Three-stage Sobel |Gx|+|Gy| edge detector on the matrix generator's 3x3 window stream.
// Define SOBEL_BORDER_MASK_EN to blank windows whose line buffers/taps are not yet filled.
module vip_sobel_edge_detector_8bit #(
    parameter logic [7:0] THRESHOLD = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       matrix_frame_vsync,
    input  logic       matrix_frame_href,
    input  logic       matrix_frame_clken,
    input  logic [7:0] matrix_p11,
    input  logic [7:0] matrix_p12,
    input  logic [7:0] matrix_p13,
    input  logic [7:0] matrix_p21,
    input  logic [7:0] matrix_p22,
    input  logic [7:0] matrix_p23,
    input  logic [7:0] matrix_p31,
    input  logic [7:0] matrix_p32,
    input  logic [7:0] matrix_p33,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_y,
    output logic       post_img_bit
);

    logic [9:0]  gx_p, gx_n, gy_p, gy_n;
    logic [9:0]  abs_gx, abs_gy;
    logic [10:0] sum;
    logic [2:0]  vsync_sr, href_sr, clken_sr;
    logic        mask_now, mask_s1, mask_s2;

`ifdef SOBEL_BORDER_MASK_EN
    logic [1:0] col_cnt, row_cnt;
    logic       vsync_d, href_d;

    // Mask uses counter values before this strobe's increment.
    assign mask_now = (row_cnt < 2'd2) || (col_cnt < 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= matrix_frame_vsync;
            href_d  <= matrix_frame_href;
            if (!matrix_frame_href)
                col_cnt <= '0;
            else if (matrix_frame_clken && col_cnt != 2'd3)
                col_cnt <= col_cnt + 2'd1;
            if (matrix_frame_vsync && !vsync_d)
                row_cnt <= '0;
            else if (href_d && !matrix_frame_href && row_cnt != 2'd3)
                row_cnt <= row_cnt + 2'd1;
        end
    end
`else
    assign mask_now = 1'b0;
`endif

    assign sum = {1'b0, abs_gx} + {1'b0, abs_gy};

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_p             <= '0;
            gx_n             <= '0;
            gy_p             <= '0;
            gy_n             <= '0;
            abs_gx           <= '0;
            abs_gy           <= '0;
            mask_s1          <= 1'b0;
            mask_s2          <= 1'b0;
            post_img_y       <= '0;
            post_img_bit     <= 1'b0;
            vsync_sr         <= '0;
            href_sr          <= '0;
            clken_sr         <= '0;
        end else begin
            gx_p    <= {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
            gx_n    <= {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
            gy_p    <= {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
            gy_n    <= {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
            mask_s1 <= mask_now;

            abs_gx  <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
            abs_gy  <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
            mask_s2 <= mask_s1;

            // Threshold compares the unsaturated sum.
            if (mask_s2) begin
                post_img_y   <= '0;
                post_img_bit <= 1'b0;
            end else begin
                post_img_y   <= (sum > 11'd255) ? 8'hFF : sum[7:0];
                post_img_bit <= (sum > {3'b000, THRESHOLD});
            end

            vsync_sr <= {vsync_sr[1:0], matrix_frame_vsync};
            href_sr  <= {href_sr[1:0],  matrix_frame_href};
            clken_sr <= {clken_sr[1:0], matrix_frame_clken};
        end
    end

    assign post_frame_vsync = vsync_sr[2];
    assign post_frame_href  = href_sr[2];
    assign post_frame_clken = clken_sr[2];

    logic unused_p22;
    assign unused_p22 = ^matrix_p22;

endmodule

// File: tb/tb_vip_sobel_edge_detector_8bit.sv
// Scoreboard bench for the Sobel detector: driver pushes per-cycle expectations, monitor checks outputs.
module tb_vip_sobel_edge_detector_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs, hs, ce;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic       o_vs, o_hs, o_ce, o_bit;
    logic [7:0] o_y;
    logic       t_vs, t_hs, t_ce, t_bit;
    logic [7:0] t_y;

    always #5 clk = ~clk;

    vip_sobel_edge_detector_8bit dut (
        .clk(clk), .rst(rst),
        .matrix_frame_vsync(vs), .matrix_frame_href(hs), .matrix_frame_clken(ce),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .post_frame_vsync(o_vs), .post_frame_href(o_hs), .post_frame_clken(o_ce),
        .post_img_y(o_y), .post_img_bit(o_bit)
    );

    vip_sobel_edge_detector_8bit #(.THRESHOLD(8'd39)) dut39 (
        .clk(clk), .rst(rst),
        .matrix_frame_vsync(vs), .matrix_frame_href(hs), .matrix_frame_clken(ce),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .post_frame_vsync(t_vs), .post_frame_href(t_hs), .post_frame_clken(t_ce),
        .post_img_y(t_y), .post_img_bit(t_bit)
    );

    typedef struct {
        bit rst, vs, hs, ce;
        int y;
        bit b64, b39;
    } rec_t;

    rec_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   win[9];          // p11,p12,p13,p21,p22,p23,p31,p32,p33
    int   line_idx, pix_idx;
    bit   prev_vs, prev_hs;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Straight Sobel kernels with integer arithmetic.
    function automatic int sobel_sum();
        int gx, gy;
        gx = (win[2] + 2*win[5] + win[8]) - (win[0] + 2*win[3] + win[6]);
        gy = (win[6] + 2*win[7] + win[8]) - (win[0] + 2*win[1] + win[2]);
        return iabs(gx) + iabs(gy);
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be three edges later.
    task automatic drive(input bit r, input bit v, input bit h, input bit c);
        rec_t rc;
        int   s;
        bit   m;
        rst = r; vs = v; hs = h; ce = c;
        p11 = 8'(win[0]); p12 = 8'(win[1]); p13 = 8'(win[2]);
        p21 = 8'(win[3]); p22 = 8'(win[4]); p23 = 8'(win[5]);
        p31 = 8'(win[6]); p32 = 8'(win[7]); p33 = 8'(win[8]);
        s = sobel_sum();
`ifdef SOBEL_BORDER_MASK_EN
        m = (line_idx < 2) || (pix_idx < 2);
`else
        m = 1'b0;
`endif
        if (r) begin
            line_idx = 0; pix_idx = 0; prev_vs = 0; prev_hs = 0;
        end else begin
            if (v && !prev_vs) line_idx = 0;
            else if (prev_hs && !h) line_idx++;
            if (!h) pix_idx = 0;
            else if (c) pix_idx++;
            prev_vs = v; prev_hs = h;
        end
        rc.rst = r; rc.vs = v; rc.hs = h; rc.ce = c;
        rc.y   = m ? 0 : ((s > 255) ? 255 : s);
        rc.b64 = !m && (s > 64);
        rc.b39 = !m && (s > 39);
        q.push_back(rc);
        @(posedge clk);
        #1;
    endtask

    task automatic set_cols(input int a, input int b, input int c);
        for (int r = 0; r < 3; r++) begin
            win[3*r] = a; win[3*r+1] = b; win[3*r+2] = c;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 9; i++) win[i] = int'($urandom_range(0, 255));
    endtask

    task automatic frame(input int lines, input int pixels, input int rst_at);
        int n;
        n = 0;
        set_cols(0, 50, 100);
        drive(0, 1, 0, 0); drive(0, 1, 0, 0);
        drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < pixels; p++) begin
                drive(n == rst_at, 0, 1, 1);
                n++;
            end
            drive(0, 0, 0, 0); drive(0, 0, 0, 0);
        end
    endtask

    // Monitor: every edge presents one output slot; zero if reset touched any of the last three edges.
    initial begin
        rec_t w0, w1, w2, e;
        bit   z;
        w0.rst = 1; w1.rst = 1; w2.rst = 1;
        forever begin
            @(posedge clk);
            if (q.size() != 0) begin
                w2 = w1; w1 = w0; w0 = q.pop_front();
                #2;
                z = w0.rst || w1.rst || w2.rst;
                e = w2;
                chk("vsync", int'(o_vs), z ? 0 : int'(e.vs));
                chk("href",  int'(o_hs), z ? 0 : int'(e.hs));
                chk("clken", int'(o_ce), z ? 0 : int'(e.ce));
                chk("clken_t39", int'(t_ce), z ? 0 : int'(e.ce));
                if (z || e.ce) begin
                    chk("img_y",     int'(o_y),   z ? 0 : e.y);
                    chk("img_bit",   int'(o_bit), z ? 0 : int'(e.b64));
                    chk("img_y_t39", int'(t_y),   z ? 0 : e.y);
                    chk("img_bit_t39", int'(t_bit), z ? 0 : int'(e.b39));
                end
            end
        end
    end

    initial begin
        line_idx = 0; pix_idx = 0; prev_vs = 0; prev_hs = 0;
        // Reset held with busy nonzero inputs, then release.
        for (int i = 0; i < 4; i++) begin
            set_rand();
            drive(1, 1, 1, 1);
        end
        for (int i = 0; i < 4; i++) begin
            set_rand();
            drive(0, 0, 1, 1);
        end
        // Directed windows: vertical edge, weak gradient, threshold boundary (sums 64 and 66).
        set_cols(0, 50, 100);  drive(0, 0, 1, 1);
        set_cols(10, 15, 20);  drive(0, 0, 1, 1);
        set_cols(0, 0, 16);    drive(0, 0, 1, 1);
        set_cols(0, 0, 16); win[8] = 17; win[1] = 1; drive(0, 0, 1, 1);
        set_cols(77, 77, 77);  drive(0, 0, 1, 1);
        set_cols(0, 50, 100);  drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        // Two lines of eight pixels with random clken and pixel data.
        drive(0, 1, 0, 0);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 8; p++) begin
                set_rand();
                drive(0, 0, 1, 1'($urandom_range(0, 1)));
            end
            drive(0, 0, 0, 0);
        end
        // Strong-edge frame, then one with a reset mid-frame.
        frame(4, 6, -1);
        frame(4, 6, 9);
        // Long random run with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bit h;
            set_rand();
            if ($urandom_range(0, 3) == 0) set_cols(int'($urandom_range(0, 40)),
                int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
            h = 1'($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 19) == 0),
                  h, h & 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
